// File: rtl/tape_transport_ctrl.sv
// tape_transport_ctrl: debounced rec/play/stop buttons drive IDLE/RECORD/PLAY.
// Ports: clk, reset, btn_*, mic_in in; tick, strobes, sample_idx, end_ptr, state, LEDs out.
module tape_transport_ctrl #(
  parameter int CLK_FREQ        = 3375000,
  parameter int SAMPLE_RATE     = 8000,
  parameter int ADDR_W          = 13,
  parameter int DEBOUNCE_CYCLES = 67500,
  parameter int SILENCE_TICKS   = 16000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_rec,
  input  logic              btn_play,
  input  logic              btn_stop,
  input  logic              mic_in,
  output logic              sample_tick,
  output logic              wr_stb,
  output logic              rd_stb,
  output logic [ADDR_W+2:0] sample_idx,
  output logic              rec_done,
  output logic [ADDR_W+3:0] end_ptr,
  output logic [1:0]        state,
  output logic              rec_led,
  output logic              play_led
);

  localparam int DIVIDER = CLK_FREQ / SAMPLE_RATE;
  localparam int DW = $clog2(DIVIDER);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(SILENCE_TICKS + 1);
  localparam int IW = ADDR_W + 3;
  localparam int EW = ADDR_W + 4;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIVIDER - 1);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SIL_MAX  = SW'(SILENCE_TICKS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REC  = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;

  // bit 0 = rec, bit 1 = play, bit 2 = stop
  logic [2:0]    r_btn_s1;
  logic [2:0]    r_btn_s2;
  logic [2:0]    r_deb;
  logic [2:0]    r_deb_q;
  logic [CW-1:0] r_cnt [3];

  logic          r_mic_s1;
  logic          r_mic_s2;
  logic          r_mic_q;

  logic [1:0]    r_state;
  logic [DW-1:0] r_div;
  logic [SW-1:0] r_sil;
  logic [IW-1:0] r_idx;
  logic [EW-1:0] r_end;
  logic          r_tick;
  logic          r_wr;
  logic          r_rd;
  logic          r_rec_done;
  logic          r_rec_led;
  logic          r_play_led;

  logic [2:0]    w_press;
  logic          w_rec_p;
  logic          w_play_p;
  logic          w_stop_p;
  logic          w_mic_edge;
  logic          w_div_wrap;
  logic [SW-1:0] w_sil_next;
  logic          w_play_last;
  logic [1:0]    w_next;
  logic          w_enter;
  logic          w_run;

  assign w_press    = r_deb & ~r_deb_q;
  assign w_rec_p    = w_press[0];
  assign w_play_p   = w_press[1];
  assign w_stop_p   = w_press[2];
  assign w_mic_edge = r_mic_s2 ^ r_mic_q;
  assign w_div_wrap = (r_div == DIV_LAST);

  // a mic edge wins over a tick landing in the same cycle
  always_comb begin
    w_sil_next = r_sil;
    if (w_mic_edge) w_sil_next = '0;
    else if (r_wr)  w_sil_next = r_sil + SW'(1);
  end

  // end_ptr is nonzero whenever PLAY is entered
  assign w_play_last = r_rd && ({1'b0, r_idx} == (r_end - EW'(1)));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_stop_p)                 w_next = S_IDLE;
        else if (w_rec_p)             w_next = S_REC;
        else if (w_play_p && r_end != '0)
                                      w_next = S_PLAY;
      end
      S_REC: begin
        if (w_stop_p || w_rec_p ||
            (w_sil_next == SIL_MAX) ||
            (r_wr && (&r_idx)))
          w_next = S_IDLE;
      end
      S_PLAY: begin
        if (w_stop_p || w_play_p || w_play_last)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_enter = (r_state == S_IDLE) && (w_next != S_IDLE);
  assign w_run   = (r_state != S_IDLE) && (w_next != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_btn_s1   <= '0;
      r_btn_s2   <= '0;
      r_deb      <= '0;
      r_deb_q    <= '0;
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
      r_mic_s1   <= 1'b0;
      r_mic_s2   <= 1'b0;
      r_mic_q    <= 1'b0;
      r_state    <= S_IDLE;
      r_div      <= '0;
      r_sil      <= '0;
      r_idx      <= '0;
      r_end      <= '0;
      r_tick     <= 1'b0;
      r_wr       <= 1'b0;
      r_rd       <= 1'b0;
      r_rec_done <= 1'b0;
      r_rec_led  <= 1'b1;
      r_play_led <= 1'b1;
    end else begin
      r_btn_s1 <= {btn_stop, btn_play, btn_rec};
      r_btn_s2 <= r_btn_s1;
      for (int i = 0; i < 3; i++) begin
        if (r_btn_s2[i] != r_deb[i]) begin
          if (r_cnt[i] == DB_LAST) begin
            r_deb[i] <= r_btn_s2[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + CW'(1);
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
      r_deb_q <= r_deb;

      r_mic_s1 <= mic_in;
      r_mic_s2 <= r_mic_s1;
      r_mic_q  <= r_mic_s2;

      r_state    <= w_next;
      r_rec_led  <= (w_next != S_REC);
      r_play_led <= (w_next != S_PLAY);
      r_rec_done <= (r_state == S_REC) && (w_next == S_IDLE);

      if (w_run) begin
        r_div  <= w_div_wrap ? '0 : r_div + DW'(1);
        r_tick <= w_div_wrap;
        r_wr   <= w_div_wrap && (r_state == S_REC);
        r_rd   <= w_div_wrap && (r_state == S_PLAY);
        r_sil  <= (r_state == S_REC) ? w_sil_next : '0;
        if (r_tick) r_idx <= r_idx + IW'(1);
      end else begin
        r_div  <= '0;
        r_tick <= 1'b0;
        r_wr   <= 1'b0;
        r_rd   <= 1'b0;
        r_sil  <= '0;
        if (w_enter) r_idx <= '0;
      end

      // a strobe in the exit cycle is still counted
      if ((r_state == S_REC) && (w_next == S_IDLE))
        r_end <= {1'b0, r_idx} + EW'(r_wr);
    end
  end

  assign sample_tick = r_tick;
  assign wr_stb      = r_wr;
  assign rd_stb      = r_rd;
  assign sample_idx  = r_idx;
  assign rec_done    = r_rec_done;
  assign end_ptr     = r_end;
  assign state       = r_state;
  assign rec_led     = r_rec_led;
  assign play_led    = r_play_led;

endmodule

// File: tb/tb_tape_transport_ctrl.sv
// tb_tape_transport_ctrl: directed scenarios for tape_transport_ctrl.
// DIVIDER=10, SAMPLES=32, DEBOUNCE_CYCLES=4, SILENCE_TICKS=6.
module tb_tape_transport_ctrl;

  localparam int IW = 5;
  localparam int EW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          btn_rec = 1'b0;
  logic          btn_play = 1'b0;
  logic          btn_stop = 1'b0;
  logic          mic_in = 1'b0;
  logic          sample_tick;
  logic          wr_stb;
  logic          rd_stb;
  logic [IW-1:0] sample_idx;
  logic          rec_done;
  logic [EW-1:0] end_ptr;
  logic [1:0]    state;
  logic          rec_led;
  logic          play_led;

  int total = 0;
  int bad = 0;

  tape_transport_ctrl #(
    .CLK_FREQ(80),
    .SAMPLE_RATE(8),
    .ADDR_W(2),
    .DEBOUNCE_CYCLES(4),
    .SILENCE_TICKS(6)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_rec(btn_rec),
    .btn_play(btn_play),
    .btn_stop(btn_stop),
    .mic_in(mic_in),
    .sample_tick(sample_tick),
    .wr_stb(wr_stb),
    .rd_stb(rd_stb),
    .sample_idx(sample_idx),
    .rec_done(rec_done),
    .end_ptr(end_ptr),
    .state(state),
    .rec_led(rec_led),
    .play_led(play_led)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cyc();
    total++;
    if (state !== 2'd0 || end_ptr !== 6'd0 || sample_idx !== 5'd0) begin
      bad++;
      $display("FAIL reset_regs: state=%0d end=%0d idx=%0d want 0 0 0",
               state, end_ptr, sample_idx);
    end
    total++;
    if ({sample_tick, wr_stb, rd_stb, rec_done} !== 4'b0000 ||
        rec_led !== 1'b1 || play_led !== 1'b1) begin
      bad++;
      $display("FAIL reset_outs: tick/wr/rd/done=%b leds=%b%b want 0000 11",
               {sample_tick, wr_stb, rd_stb, rec_done}, rec_led, play_led);
    end
    reset = 1'b0;
    repeat (2) cyc();
  endtask

  // Stop pressed right after the 12th write strobe
  task automatic test_record_stop();
    int n, c, ex, done_n, idx_bad, sp_bad, led_bad;
    btn_rec = 1'b1;
    repeat (6) cyc();
    total++;
    if (state !== 2'd0) begin
      bad++;
      $display("FAIL rec_latency_early: state=%0d want 0", state);
    end
    cyc();
    total++;
    if (state !== 2'd1 || rec_led !== 1'b0 || play_led !== 1'b1) begin
      bad++;
      $display("FAIL rec_enter: state=%0d leds=%b%b want 1 01",
               state, rec_led, play_led);
    end
    n = 0; c = 0; ex = -1; done_n = 0;
    idx_bad = 0; sp_bad = 0; led_bad = 0;
    for (int t = 0; t < 400 && state == 2'd1; t++) begin
      cyc();
      c++;
      if (t == 3) btn_rec = 1'b0;
      if (wr_stb) begin
        if (sample_idx !== n[IW-1:0]) idx_bad++;
        if (c != 10 * (n + 1)) sp_bad++;
        n++;
        if (n % 3 == 0) mic_in = ~mic_in;
        if (n == 12) btn_stop = 1'b1;
      end
      if (rd_stb) idx_bad++;
      if (rec_done) done_n++;
      if (state == 2'd1 && rec_led !== 1'b0) led_bad++;
      if (state == 2'd0) ex = c;
    end
    total++;
    if (ex != 127) begin
      bad++;
      $display("FAIL rec_stop_exit: cycle=%0d want 127", ex);
    end
    total++;
    if (n != 12 || idx_bad != 0 || sp_bad != 0) begin
      bad++;
      $display("FAIL rec_strobes: n=%0d idxbad=%0d spbad=%0d want 12 0 0",
               n, idx_bad, sp_bad);
    end
    total++;
    if (end_ptr !== 6'd12 || rec_led !== 1'b1 || led_bad != 0) begin
      bad++;
      $display("FAIL rec_end: end=%0d led=%b ledbad=%0d want 12 1 0",
               end_ptr, rec_led, led_bad);
    end
    btn_stop = 1'b0;
    for (int t = 0; t < 12; t++) begin
      cyc();
      if (rec_done) done_n++;
    end
    total++;
    if (done_n != 1) begin
      bad++;
      $display("FAIL rec_done_pulse: count=%0d want 1", done_n);
    end
  endtask

  task automatic test_play();
    int n, c, ex, last, idx_bad, sp_bad, led_bad;
    btn_play = 1'b1;
    repeat (7) cyc();
    total++;
    if (state !== 2'd2 || play_led !== 1'b0 || rec_led !== 1'b1) begin
      bad++;
      $display("FAIL play_enter: state=%0d leds=%b%b want 2 10",
               state, rec_led, play_led);
    end
    n = 0; c = 0; ex = -1; last = -1;
    idx_bad = 0; sp_bad = 0; led_bad = 0;
    for (int t = 0; t < 400 && state == 2'd2; t++) begin
      cyc();
      c++;
      if (t == 3) btn_play = 1'b0;
      if (rd_stb) begin
        if (sample_idx !== n[IW-1:0]) idx_bad++;
        if (c != 10 * (n + 1)) sp_bad++;
        last = c;
        n++;
      end
      if (wr_stb || rec_done) idx_bad++;
      if (state == 2'd2 && play_led !== 1'b0) led_bad++;
      if (state == 2'd0) ex = c;
    end
    total++;
    if (n != 12 || idx_bad != 0 || sp_bad != 0) begin
      bad++;
      $display("FAIL play_strobes: n=%0d idxbad=%0d spbad=%0d want 12 0 0",
               n, idx_bad, sp_bad);
    end
    total++;
    if (ex != 121 || last != 120) begin
      bad++;
      $display("FAIL play_end_exit: exit=%0d last=%0d want 121 120", ex, last);
    end
    total++;
    if (play_led !== 1'b1 || led_bad != 0 || end_ptr !== 6'd12) begin
      bad++;
      $display("FAIL play_after: led=%b ledbad=%0d end=%0d want 1 0 12",
               play_led, led_bad, end_ptr);
    end
    repeat (12) cyc();
  endtask

  task automatic test_silence();
    int n, c, ex, done_n;
    btn_rec = 1'b1;
    repeat (7) cyc();
    total++;
    if (state !== 2'd1) begin
      bad++;
      $display("FAIL sil_enter: state=%0d want 1", state);
    end
    n = 0; c = 0; ex = -1; done_n = 0;
    for (int t = 0; t < 400 && state == 2'd1; t++) begin
      cyc();
      c++;
      if (t == 3) btn_rec = 1'b0;
      if (wr_stb) n++;
      if (rec_done) done_n++;
      if (state == 2'd0) ex = c;
    end
    total++;
    if (n != 6 || ex != 61 || end_ptr !== 6'd6 || done_n != 1) begin
      bad++;
      $display("FAIL silence_stop: n=%0d exit=%0d end=%0d done=%0d want 6 61 6 1",
               n, ex, end_ptr, done_n);
    end
    repeat (12) cyc();
  endtask

  task automatic test_full();
    int n, c, ex, idx_bad;
    btn_rec = 1'b1;
    repeat (7) cyc();
    n = 0; c = 0; ex = -1; idx_bad = 0;
    for (int t = 0; t < 800 && state == 2'd1; t++) begin
      cyc();
      c++;
      if (t == 3) btn_rec = 1'b0;
      if (wr_stb) begin
        if (sample_idx !== n[IW-1:0]) idx_bad++;
        n++;
        mic_in = ~mic_in;
      end
      if (state == 2'd0) ex = c;
    end
    total++;
    if (n != 32 || idx_bad != 0 || ex != 321) begin
      bad++;
      $display("FAIL full_strobes: n=%0d idxbad=%0d exit=%0d want 32 0 321",
               n, idx_bad, ex);
    end
    total++;
    if (end_ptr !== 6'd32 || rec_done !== 1'b1) begin
      bad++;
      $display("FAIL full_end: end=%0d done=%b want 32 1", end_ptr, rec_done);
    end
    repeat (12) cyc();
  endtask

  task automatic test_ignore_glitch_priority();
    int moved, strobes, n, c;
    reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    total++;
    if (end_ptr !== 6'd0 || state !== 2'd0) begin
      bad++;
      $display("FAIL rst_clear: end=%0d state=%0d want 0 0", end_ptr, state);
    end
    moved = 0; strobes = 0;
    btn_play = 1'b1;
    for (int t = 0; t < 24; t++) begin
      cyc();
      if (t == 12) btn_play = 1'b0;
      if (state != 2'd0) moved++;
      if (rd_stb || sample_tick) strobes++;
    end
    total++;
    if (moved != 0 || strobes != 0) begin
      bad++;
      $display("FAIL empty_play: moved=%0d strobes=%0d want 0 0", moved, strobes);
    end
    btn_rec = 1'b1;
    repeat (3) cyc();
    btn_rec = 1'b0;
    moved = 0;
    for (int t = 0; t < 20; t++) begin
      cyc();
      if (state != 2'd0) moved++;
    end
    total++;
    if (moved != 0) begin
      bad++;
      $display("FAIL glitch: moved=%0d want 0", moved);
    end
    btn_rec = 1'b1;
    btn_play = 1'b1;
    repeat (7) cyc();
    total++;
    if (state !== 2'd1) begin
      bad++;
      $display("FAIL rec_over_play: state=%0d want 1", state);
    end
    n = 0; c = 0;
    for (int t = 0; t < 400 && state == 2'd1; t++) begin
      cyc();
      c++;
      if (t == 3) begin
        btn_rec = 1'b0;
        btn_play = 1'b0;
      end
      if (wr_stb) begin
        n++;
        mic_in = ~mic_in;
        if (n == 10) btn_stop = 1'b1;
      end
    end
    total++;
    if (n != 10 || end_ptr !== 6'd10 || state !== 2'd0) begin
      bad++;
      $display("FAIL rec_ten: n=%0d end=%0d state=%0d want 10 10 0",
               n, end_ptr, state);
    end
    btn_stop = 1'b0;
    repeat (12) cyc();
  endtask

  task automatic test_reset_mid_play();
    int found, junk;
    btn_play = 1'b1;
    repeat (7) cyc();
    total++;
    if (state !== 2'd2) begin
      bad++;
      $display("FAIL mid_play_enter: state=%0d want 2", state);
    end
    found = 0;
    for (int t = 0; t < 200 && found == 0; t++) begin
      cyc();
      if (t == 3) btn_play = 1'b0;
      if (rd_stb && sample_idx == 5'd5) found = 1;
    end
    btn_play = 1'b0;
    total++;
    if (found == 0) begin
      bad++;
      $display("FAIL mid_play_idx5: found=0 want 1");
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    total++;
    if (state !== 2'd0 || rec_led !== 1'b1 || play_led !== 1'b1 ||
        end_ptr !== 6'd0) begin
      bad++;
      $display("FAIL mid_play_reset: state=%0d leds=%b%b end=%0d want 0 11 0",
               state, rec_led, play_led, end_ptr);
    end
    total++;
    if ({sample_tick, wr_stb, rd_stb, rec_done} !== 4'b0000) begin
      bad++;
      $display("FAIL mid_play_strobes: tick/wr/rd/done=%b want 0000",
               {sample_tick, wr_stb, rd_stb, rec_done});
    end
    junk = 0;
    for (int t = 0; t < 30; t++) begin
      cyc();
      if (sample_tick || wr_stb || rd_stb || rec_done || state != 2'd0) junk++;
    end
    total++;
    if (junk != 0) begin
      bad++;
      $display("FAIL post_reset_quiet: events=%0d want 0", junk);
    end
  endtask

  initial begin
    test_reset();
    test_record_stop();
    test_play();
    test_silence();
    test_full();
    test_ignore_glitch_priority();
    test_reset_mid_play();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
